// File: rtl/float_combine_arbiter.sv
// Round-robin arbiter sharing one float normalise/pack unit between NUM_REQ requesters.
// Optional canonical-NaN override enabled by defining FLOAT_COMBINE_ARB_NAN_EN.
module float_combine_arbiter #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int NUM_REQ = 4,
  localparam int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_sign,
  input  logic [NUM_REQ*(EXP_WIDTH+2)-1:0]  req_exp,
  input  logic [NUM_REQ*(MAN_WIDTH+3)-1:0]  req_man,
`ifdef FLOAT_COMBINE_ARB_NAN_EN
  input  logic [NUM_REQ-1:0]                req_nan,
`endif
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [FLOAT_WIDTH-1:0]            res_data,
  output logic [ID_WIDTH-1:0]               res_id,
  output logic                              busy
);

  localparam int EW  = EXP_WIDTH + 2;
  localparam int MW  = MAN_WIDTH + 3;
  localparam int LW  = $clog2(MAN_WIDTH + 2);
  localparam int IW1 = ID_WIDTH + 1;
  localparam logic signed [EW:0] EXP_MAX = {3'b000, {EXP_WIDTH{1'b1}}};

  logic [EW-1:0]          exp_arr [NUM_REQ];
  logic [MAN_WIDTH+1:0]   man_arr [NUM_REQ];
  logic [NUM_REQ-1:0]     man_top_unused;

  // The mantissa MSB of every requester is architecturally ignored.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign exp_arr[gi]        = req_exp[gi*EW +: EW];
      assign man_arr[gi]        = req_man[gi*MW +: MAN_WIDTH+2];
      assign man_top_unused[gi] = req_man[gi*MW + MW - 1];
    end
  endgenerate

  logic [ID_WIDTH-1:0]    ptr_reg;
  logic                   s1_valid_reg, s1_valid_next;
  logic                   s1_sign_reg;
  logic [EW-1:0]          s1_exp_reg;
  logic [MAN_WIDTH+1:0]   s1_man_reg;
  logic [ID_WIDTH-1:0]    s1_id_reg;
  logic                   res_valid_reg, res_valid_next;
  logic [FLOAT_WIDTH-1:0] res_data_reg;
  logic [ID_WIDTH-1:0]    res_id_reg;

  logic [ID_WIDTH-1:0]    grant;
  logic [IW1-1:0]         cand_w;
  logic                   any_valid, can_accept, take, s1_advance;

  assign any_valid  = |req_valid;
  assign s1_advance = s1_valid_reg && (!res_valid_reg || res_ready);
  assign can_accept = !s1_valid_reg || s1_advance;
  assign take       = any_valid && can_accept;

  // Scan from lowest to highest priority so the closest requester after ptr wins.
  always_comb begin
    grant  = '0;
    cand_w = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_w = {1'b0, ptr_reg} + IW1'(k);
      if (cand_w >= IW1'(NUM_REQ))
        cand_w = cand_w - IW1'(NUM_REQ);
      if (req_valid[cand_w[ID_WIDTH-1:0]])
        grant = cand_w[ID_WIDTH-1:0];
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && take)
      req_ready[grant] = 1'b1;
  end

  always_comb begin
    s1_valid_next = s1_valid_reg;
    if (take)
      s1_valid_next = 1'b1;
    else if (s1_advance)
      s1_valid_next = 1'b0;
  end

  always_comb begin
    res_valid_next = res_valid_reg;
    if (s1_advance)
      res_valid_next = 1'b1;
    else if (res_ready)
      res_valid_next = 1'b0;
  end

  // Normalise and pack: truncating, overflow saturates to infinity, underflow flushes to zero.
  logic [LW-1:0]          lead;
  logic [LW-1:0]          shift;
  logic signed [EW:0]     exp_s;
  logic signed [EW:0]     exp_adj;
  logic [MAN_WIDTH-1:0]   frac;
  logic [FLOAT_WIDTH-1:0] packed_res;
  logic [FLOAT_WIDTH-1:0] s2_load;

  always_comb begin
    lead       = '0;
    shift      = '0;
    exp_s      = {s1_exp_reg[EW-1], s1_exp_reg};
    exp_adj    = exp_s;
    frac       = '0;
    packed_res = '0;
    for (int i = 0; i <= MAN_WIDTH + 1; i++)
      if (s1_man_reg[i])
        lead = LW'(i);
    if (s1_man_reg[MAN_WIDTH+1]) begin
      frac    = s1_man_reg[MAN_WIDTH:1];
      exp_adj = exp_s + (EW+1)'(1);
    end else begin
      shift   = LW'(MAN_WIDTH) - lead;
      frac    = s1_man_reg[MAN_WIDTH-1:0] << shift;
      exp_adj = exp_s - {{(EW+1-LW){1'b0}}, shift};
    end
    if (s1_man_reg == '0)
      packed_res = {s1_sign_reg, {(FLOAT_WIDTH-1){1'b0}}};
    else if (exp_adj >= EXP_MAX)
      packed_res = {s1_sign_reg, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
    else if (exp_adj[EW] || exp_adj == '0)
      packed_res = {s1_sign_reg, {(FLOAT_WIDTH-1){1'b0}}};
    else
      packed_res = {s1_sign_reg, exp_adj[EXP_WIDTH-1:0], frac};
  end

`ifdef FLOAT_COMBINE_ARB_NAN_EN
  logic s1_nan_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      s1_nan_reg <= 1'b0;
    else if (take)
      s1_nan_reg <= req_nan[grant];
  end

  assign s2_load = s1_nan_reg ? {s1_sign_reg, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}}
                              : packed_res;
`else
  assign s2_load = packed_res;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      ptr_reg      <= ID_WIDTH'(NUM_REQ - 1);
      s1_sign_reg  <= 1'b0;
      s1_exp_reg   <= '0;
      s1_man_reg   <= '0;
      s1_id_reg    <= '0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      if (take) begin
        ptr_reg     <= grant;
        s1_sign_reg <= req_sign[grant];
        s1_exp_reg  <= exp_arr[grant];
        s1_man_reg  <= man_arr[grant];
        s1_id_reg   <= grant;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= '0;
    end else begin
      res_valid_reg <= res_valid_next;
      if (s1_advance) begin
        res_data_reg <= s2_load;
        res_id_reg   <= s1_id_reg;
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign busy      = s1_valid_reg | res_valid_reg;

endmodule

// File: tb/tb_float_combine_arbiter.sv
// Self-checking bench for float_combine_arbiter (FP32, four requesters).
// Request/result monitors feed scoreboard queues that each test drains and compares.
module tb_float_combine_arbiter;
  localparam int NR = 4;
  localparam int EW = 10;
  localparam int MW = 26;
  localparam int FW = 32;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_sign;
  logic [NR*EW-1:0]  req_exp;
  logic [NR*MW-1:0]  req_man;
`ifdef FLOAT_COMBINE_ARB_NAN_EN
  logic [NR-1:0]     req_nan;
`endif
  logic              res_valid;
  logic              res_ready;
  logic [FW-1:0]     res_data;
  logic [1:0]        res_id;
  logic              busy;

  float_combine_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sign  (req_sign),
    .req_exp   (req_exp),
    .req_man   (req_man),
`ifdef FLOAT_COMBINE_ARB_NAN_EN
    .req_nan   (req_nan),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus vectors with hand-derived FP32 results.
  localparam logic       TV_SIGN [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [9:0] TV_EXP  [8] = '{10'd127, 10'd126, 10'd128, 10'd127,
                                         10'd255, 10'd127, 10'd129, 10'd130};
  localparam logic [25:0] TV_MAN [8] = '{26'h0800000, 26'h1000000, 26'h0C00000, 26'h0800000,
                                         26'h0800000, 26'h0000000, 26'h0A00000, 26'h0400000};
  localparam logic [31:0] TV_RES [8] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'hBF800000,
                                         32'h7F800000, 32'h00000000, 32'h40A00000, 32'h40800000};

  logic [31:0] exp_res [NR];
  logic [33:0] exp_q [$];
  logic [33:0] obs_q [$];
  int          obs_cyc [$];
  int          hs_cnt;
  int          cyc;
  int          chk_cnt;
  int          pass_cnt;

  initial begin
    hs_cnt = 0;
    cyc    = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Capture each accepted request with its expected result.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({2'(i), exp_res[i]});
          hs_cnt <= hs_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      obs_q.push_back({res_id, res_data});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int r, input int v);
    req_sign[r]          = TV_SIGN[v];
    req_exp[r*EW +: EW]  = TV_EXP[v];
    req_man[r*MW +: MW]  = TV_MAN[v];
    exp_res[r]           = TV_RES[v];
`ifdef FLOAT_COMBINE_ARB_NAN_EN
    req_nan[r]           = 1'b0;
`endif
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, i);
    tick(); tick();
    chk_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got=%0b exp=0", res_valid); else pass_cnt++;
    chk_cnt++; if (res_data !== 32'h0) $display("FAIL reset_res_data got=%h exp=0", res_data); else pass_cnt++;
    chk_cnt++; if (res_id !== 2'd0) $display("FAIL reset_res_id got=%0d exp=0", res_id); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else pass_cnt++;
    reset_n = 1'b1;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL reset_first_grant got=%b exp=0001", req_ready); else pass_cnt++;
    req_valid = '0;
    clear_sb();
    tick();
  endtask

  task automatic test_single();
    logic [33:0] o, e;
    res_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      set_req(0, v);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      chk_cnt++; if (res_valid !== 1'b0) $display("FAIL single%0d_early_valid got=%0b exp=0", v, res_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL single%0d_busy_s1 got=%0b exp=1", v, busy); else pass_cnt++;
      tick();
      chk_cnt++; if (res_valid !== 1'b1) $display("FAIL single%0d_valid got=%0b exp=1", v, res_valid); else pass_cnt++;
      chk_cnt++; if (res_data !== TV_RES[v]) $display("FAIL single%0d_data got=%h exp=%h", v, res_data, TV_RES[v]); else pass_cnt++;
      chk_cnt++; if (res_id !== 2'd0) $display("FAIL single%0d_id got=%0d exp=0", v, res_id); else pass_cnt++;
      tick();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL single%0d_busy_idle got=%0b exp=0", v, busy); else pass_cnt++;
    end
    chk_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      $display("txn single id=%0d data=%h", o[33:32], o[31:0]);
      chk_cnt++; if (o !== e) $display("FAIL single_sb got=%h exp=%h", o, e); else pass_cnt++;
    end
    clear_sb();
  endtask

  task automatic test_round_robin();
    logic [33:0] o, e;
    int base, n, prev_c, c, j;
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    clear_sb();
    set_req(0, 0); set_req(1, 2); set_req(2, 3); set_req(3, 6);
    res_ready = 1'b1;
    base = hs_cnt;
    n = 0;
    req_valid = 4'b1111;
    while (hs_cnt - base < 8 && n < 40) begin
      tick();
      n++;
    end
    req_valid = '0;
    chk_cnt++; if (n !== 8) $display("FAIL rr_cycles got=%0d exp=8", n); else pass_cnt++;
    tick(); tick(); tick();
    chk_cnt++; if (obs_q.size() !== 8) $display("FAIL rr_count got=%0d exp=8", obs_q.size()); else pass_cnt++;
    chk_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL rr_sb_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    j = 0;
    prev_c = -1;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); c = obs_cyc.pop_front();
      $display("txn rr id=%0d data=%h", o[33:32], o[31:0]);
      chk_cnt++; if (o[33:32] !== 2'(j % 4)) $display("FAIL rr_order got=%0d exp=%0d", o[33:32], j % 4); else pass_cnt++;
      chk_cnt++; if (o !== e) $display("FAIL rr_sb got=%h exp=%h", o, e); else pass_cnt++;
      if (prev_c >= 0) begin
        chk_cnt++; if (c - prev_c !== 1) $display("FAIL rr_gap got=%0d exp=1", c - prev_c); else pass_cnt++;
      end
      prev_c = c;
      j++;
    end
    clear_sb();
  endtask

  task automatic test_backpressure();
    logic [33:0] o, e;
    logic [31:0] held_data;
    logic [1:0]  held_id;
    int base, n;
    set_req(0, 4); set_req(1, 5); set_req(2, 7); set_req(3, 2);
    res_ready = 1'b0;
    base = hs_cnt;
    req_valid = 4'b1111;
    n = 0;
    while (!res_valid && n < 10) begin
      tick();
      n++;
    end
    chk_cnt++; if (res_valid !== 1'b1) $display("FAIL bp_fill got=%0b exp=1", res_valid); else pass_cnt++;
    held_data = res_data;
    held_id   = res_id;
    for (int k = 0; k < 5; k++) begin
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_ready%0d got=%b exp=0000", k, req_ready); else pass_cnt++;
      chk_cnt++; if ({res_valid, res_id, res_data} !== {1'b1, held_id, held_data})
        $display("FAIL bp_hold%0d got=%0b/%0d/%h exp=1/%0d/%h", k, res_valid, res_id, res_data, held_id, held_data); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (hs_cnt - base !== 2) $display("FAIL bp_captured got=%0d exp=2", hs_cnt - base); else pass_cnt++;
    req_valid = '0;
    res_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL bp_drain_busy got=%0b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (obs_q.size() !== 2 || exp_q.size() !== 2)
      $display("FAIL bp_count got=%0d/%0d exp=2/2", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      $display("txn bp id=%0d data=%h", o[33:32], o[31:0]);
      chk_cnt++; if (o !== e) $display("FAIL bp_sb got=%h exp=%h", o, e); else pass_cnt++;
    end
    clear_sb();
  endtask

  task automatic test_reset_midstream();
    logic [33:0] o;
    for (int i = 0; i < NR; i++) set_req(i, i + 2);
    res_ready = 1'b0;
    req_valid = 4'b1111;
    tick(); tick();
    chk_cnt++; if ({busy, res_valid} !== 2'b11) $display("FAIL mid_full got=%b exp=11", {busy, res_valid}); else pass_cnt++;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk_cnt++; if (res_valid !== 1'b0) $display("FAIL mid_res_valid got=%0b exp=0", res_valid); else pass_cnt++;
    chk_cnt++; if (res_data !== 32'h0) $display("FAIL mid_res_data got=%h exp=0", res_data); else pass_cnt++;
    chk_cnt++; if (res_id !== 2'd0) $display("FAIL mid_res_id got=%0d exp=0", res_id); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy got=%0b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL mid_req_ready got=%b exp=0000", req_ready); else pass_cnt++;
    clear_sb();
    tick(); tick();
    reset_n   = 1'b1;
    res_ready = 1'b1;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant got=%b exp=0001", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk_cnt++; if (obs_q.size() !== 1) $display("FAIL mid_count got=%0d exp=1", obs_q.size()); else pass_cnt++;
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      $display("txn mid id=%0d data=%h", o[33:32], o[31:0]);
      chk_cnt++; if (o !== {2'd0, TV_RES[2]}) $display("FAIL mid_result got=%h exp=%h", o, {2'd0, TV_RES[2]}); else pass_cnt++;
    end
    clear_sb();
  endtask

`ifdef FLOAT_COMBINE_ARB_NAN_EN
  task automatic test_nan();
    set_req(2, 0);
    req_sign[2] = 1'b1;
    req_nan[2]  = 1'b1;
    exp_res[2]  = 32'hFFC00000;
    res_ready   = 1'b1;
    req_valid   = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    chk_cnt++; if (res_data !== 32'hFFC00000) $display("FAIL nan_data got=%h exp=ffc00000", res_data); else pass_cnt++;
    chk_cnt++; if (res_id !== 2'd2) $display("FAIL nan_id got=%0d exp=2", res_id); else pass_cnt++;
    tick();
    chk_cnt++; if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0])
      $display("FAIL nan_sb got=%0d entries exp=1", obs_q.size()); else pass_cnt++;
    req_nan[2] = 1'b0;
    clear_sb();
  endtask
`endif

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    req_sign  = '0;
    req_exp   = '0;
    req_man   = '0;
    res_ready = 1'b0;
`ifdef FLOAT_COMBINE_ARB_NAN_EN
    req_nan   = '0;
`endif
    for (int i = 0; i < NR; i++) exp_res[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midstream();
`ifdef FLOAT_COMBINE_ARB_NAN_EN
    test_nan();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached before completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/float_combine_arbiter.md
Name: float_combine_arbiter

Overview:
- Shares one float_combine normalisation/packing unit between NUM_REQ requesters. Typical requesters are the matmul PE accumulators that need to emit packed results.
- Round-robin arbitration with a valid/ready handshake per requester.
- Two-stage pipeline: operand register, then result register. Sustains one result per cycle.
- Returns the packed float together with the index of the requester that produced it.

Parameters:
- EXP_WIDTH, 8: exponent width of the packed float.
- MAN_WIDTH, 23: stored mantissa width. FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH.
- NUM_REQ, 4: number of requesters, 2..16. ID_WIDTH = clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready; at most one bit set.
- req_sign  in  NUM_REQ  per-requester sign.
- req_exp  in  NUM_REQ*(EXP_WIDTH+2)  packed unnormalised exponents; requester i at slice i.
- req_man  in  NUM_REQ*(MAN_WIDTH+3)  packed unnormalised mantissas; requester i at slice i.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready.
- res_data  out  FLOAT_WIDTH  packed result.
- res_id  out  ID_WIDTH  requester index of res_data.
- busy  out  1  high while either pipeline stage holds data.

Behaviour:
- Reset (async, while reset_n=0):
  - res_valid=0, res_data=0, res_id=0, busy=0, req_ready=0.
  - Both stage-valid flags cleared; RR pointer = NUM_REQ-1, so requester 0 has top priority first.
  - Reset mid-operation discards in-flight data with no result emitted.
- Arbitration (combinational):
  - grant = first set req_valid bit scanning upward from (ptr+1) mod NUM_REQ, with wrap-around.
  - req_ready[grant] = can_accept. All other req_ready bits are 0.
  - can_accept = !s1_valid || s1_advance.
  - Requester protocol: valid must not depend on ready; valid and data are held stable until the handshake.
- Handshake: req_valid[g] & req_ready[g] at an edge captures sign/exp/man of g and g itself into stage 1, and sets ptr=g. With no handshake, ptr is unchanged.
- Stage 1:
  - Operand register feeds float_combine combinationally, with man[MAN_WIDTH+2] forced to 0.
  - s1_advance = s1_valid && (!res_valid || res_ready).
- Stage 2: on s1_advance, res_data/res_id are loaded and res_valid=1.
  - res_valid clears on res_valid & res_ready if no new s1_advance happens in the same cycle.
- Latency: handshake at edge t, res_valid high after edge t+1, so the result is visible 2 cycles after the request was presented.
- Throughput: back-to-back handshakes every cycle while res_ready=1.
- Backpressure: while res_valid & !res_ready, res_data/res_id stay stable. Stage 1 holds and req_ready is all-0 if s1_valid.
- Simultaneous events:
  - Drain and refill of stage 2 in the same cycle keeps res_valid=1 with the new data.
  - Capture into stage 1 while stage 1 advances is legal.
- busy = s1_valid | res_valid.
- No reordering: results emerge in grant order.

Optional Feature:
- Macro FLOAT_COMBINE_ARB_NAN_EN.
- When defined:
  - Adds port req_nan (in, NUM_REQ). It is captured with the operands.
  - If set, stage 2 loads the canonical quiet NaN instead of the float_combine output: req_sign, exp all ones, mantissa MSB=1, remaining mantissa bits 0. Example for FP32 with sign 0: 0x7FC00000.
- When undefined: no req_nan port, and every result comes from float_combine.

Test Plan (FP32 defaults):
- Single request: req0 valid, sign=0, exp=127, man=0x0800000, res_ready=1 -> res_valid 2 cycles later, res_data=0x3F800000, res_id=0, busy falls the following cycle.
- Other encodings: exp=126, man=0x1000000 -> 0x3F800000. exp=128, man=0x0C00000 -> 0x40400000. Sign=1, exp=127, man=0x0800000 -> 0xBF800000. exp=255, man=0x0800000 -> 0x7F800000. man=0, exp=127 -> 0x00000000.
- Round-robin: all 4 requesters continuously valid with distinct data for 8 handshakes -> res_id sequence 0,1,2,3,0,1,2,3 with results every cycle.
- Backpressure: res_ready=0 for 5 cycles with requests pending -> res_data/res_id stable, exactly one further request captured, req_ready all-0 thereafter. Release -> no loss or duplication.
- Reset mid-stream: assert reset_n=0 asynchronously between edges with both stages full -> outputs zero immediately. After release, first grant goes to requester 0.
- With FLOAT_COMBINE_ARB_NAN_EN: req2 with req_nan=1, sign=1 -> res_data=0xFFC00000, res_id=2.
